// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
// Angles and results are signed Q7.8 fixed point.
package cordic_pkg;

  localparam int FRAC_BITS = 8;

  typedef logic signed [15:0] fixed_t;

  // x0 = 1/K pre-scales the rotation so the core output needs no gain correction.
  localparam fixed_t CORDIC_X0 = 16'sh009B;
  localparam fixed_t Z_LIMIT   = fixed_t'(90 << FRAC_BITS);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after
// the pointer, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [IdxW-1:0] o_idx
);

  always_comb begin : p_arb
    int unsigned j;
    logic        found;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!found && i_req[j]) begin
        found      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one rotation-mode CORDIC core among N_REQ requesters, with round-robin
// arbitration, angle range check, fixed-latency capture and a tagged response.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CORDIC_LAT = 18,
  localparam int unsigned IdW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*DATA_W-1:0] req_z_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [IdW-1:0]          resp_id_o,
  output logic [DATA_W-1:0]       resp_cos_o,
  output logic [DATA_W-1:0]       resp_sin_o,
  output logic                    resp_err_o,
  output logic                    core_start_o,
  output logic [DATA_W-1:0]       core_x0_o,
  output logic [DATA_W-1:0]       core_y0_o,
  output logic [DATA_W-1:0]       core_z0_o,
  input  logic [DATA_W-1:0]       core_xn_i,
  input  logic [DATA_W-1:0]       core_yn_i
);

  localparam int unsigned CntW = $clog2(CORDIC_LAT);
  localparam logic signed [DATA_W-1:0] ZMax = DATA_W'(Z_LIMIT);
  localparam logic signed [DATA_W-1:0] ZMin = -ZMax;

  sched_state_t r_state, w_state_d;

  logic [IdW-1:0]    r_ptr;
  logic [IdW-1:0]    r_id;
  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_cos;
  logic [DATA_W-1:0] r_sin;
  logic              r_err;
  logic [DATA_W-1:0] r_z0;

  logic [N_REQ-1:0]         w_grant;
  logic [IdW-1:0]           w_idx;
  logic                     w_accept;
  logic signed [DATA_W-1:0] w_req_z;
  logic                     w_in_range;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .i_req  (req_valid_i),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );

  assign w_accept   = (r_state == StIdle) && (|w_grant);
  assign w_req_z    = req_z_i[w_idx*DATA_W +: DATA_W];
  assign w_in_range = (w_req_z <= ZMax) && (w_req_z >= ZMin);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = w_in_range ? StIssue : StResp;
        end
      end
      StIssue: w_state_d = StWait;
      StWait: begin
        if (r_cnt == '0) begin
          w_state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
      r_cos   <= '0;
      r_sin   <= '0;
      r_err   <= 1'b0;
      r_z0    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_id  <= w_idx;
        r_ptr <= (w_idx == IdW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        if (w_in_range) begin
          r_z0 <= w_req_z;
        end else begin
          r_cos <= '0;
          r_sin <= '0;
          r_err <= 1'b1;
        end
      end
      if (r_state == StIssue) begin
        r_cnt <= CntW'(CORDIC_LAT - 1);
      end
      // Core outputs are only meaningful on the final countdown edge.
      if (r_state == StWait) begin
        if (r_cnt == '0) begin
          r_cos <= core_xn_i;
          r_sin <= core_yn_i;
          r_err <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign req_ready_o  = (r_state == StIdle) ? w_grant : '0;
  assign core_start_o = (r_state == StIssue);
  assign core_x0_o    = DATA_W'(CORDIC_X0);
  assign core_y0_o    = '0;
  assign core_z0_o    = r_z0;
  assign resp_valid_o = (r_state == StResp);
  assign resp_id_o    = r_id;
  assign resp_cos_o   = r_cos;
  assign resp_sin_o   = r_sin;
  assign resp_err_o   = r_err;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: a fixed-latency core model plus a transaction-level
// reference for arbitration order, range check, timing and results.
module tb_cordic_scheduler;

  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 18;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_z_i;
  logic           resp_valid_o;
  logic           resp_ready_i = 1'b0;
  logic [1:0]     resp_id_o;
  logic [W-1:0]   resp_cos_o, resp_sin_o;
  logic           resp_err_o;
  logic           core_start_o;
  logic [W-1:0]   core_x0_o, core_y0_o, core_z0_o;
  logic [W-1:0]   core_xn_i, core_yn_i;

  logic [W-1:0] z_arr [N];
  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_z
    assign req_z_i[g*W +: W] = z_arr[g];
  end

  cordic_scheduler #(.N_REQ(N), .DATA_W(W), .CORDIC_LAT(L)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_z_i     (req_z_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_id_o   (resp_id_o),
    .resp_cos_o  (resp_cos_o),
    .resp_sin_o  (resp_sin_o),
    .resp_err_o  (resp_err_o),
    .core_start_o(core_start_o),
    .core_x0_o   (core_x0_o),
    .core_y0_o   (core_y0_o),
    .core_z0_o   (core_z0_o),
    .core_xn_i   (core_xn_i),
    .core_yn_i   (core_yn_i)
  );

  // Core model: result valid only in the cycle before edge start+L, junk otherwise.
  int           m_cnt;
  logic [W-1:0] m_z, m_junk_x, m_junk_y;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_z   <= '0;
    end else begin
      m_junk_x <= W'($urandom);
      m_junk_y <= W'($urandom);
      if (core_start_o) begin
        m_cnt <= L;
        m_z   <= core_z0_o;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end
  assign core_xn_i = (m_cnt == 1) ? (m_z ^ 16'h14F1) : m_junk_x;
  assign core_yn_i = (m_cnt == 1) ? (m_z ^ 16'h1458) : m_junk_y;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs();
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_id", resp_id_o, 0);
    chk("rst_cos", resp_cos_o, 0);
    chk("rst_sin", resp_sin_o, 0);
    chk("rst_err", resp_err_o, 0);
    chk("rst_start", core_start_o, 0);
    chk("rst_x0", core_x0_o, 16'h009B);
    chk("rst_y0", core_y0_o, 0);
    chk("rst_z0", core_z0_o, 0);
  endtask

  function automatic logic [W-1:0] rand_z(input bit inr);
    int v;
    v = inr ? $urandom_range(0, 23040) : $urandom_range(23041, 32768);
    if ($urandom_range(0, 1) == 1) v = -v;
    return W'(v);
  endfunction

  // One full transaction: grant, issue/skip, latency, result, optional stall, handshake.
  task automatic serve(input int stall, output int served);
    int g, lat, starts;
    logic [W-1:0] z, ec, es;
    bit inr;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (g < 0 && req_valid_i[j]) g = j;
    end
    served = g;
    if (g < 0) return;
    @(negedge clk);
    chk("grant", req_ready_o, 1 << g);
    z = z_arr[g];
    @(posedge clk); #1;
    req_valid_i[g] = 1'b0;
    m_ptr = (g + 1) % N;
    inr = ($signed(z) >= -23040) && ($signed(z) <= 23040);
    starts = core_start_o ? 1 : 0;
    lat = 0;
    chk("ready_busy", req_ready_o, 0);
    if (inr) begin
      chk("z0", core_z0_o, z);
      chk("x0", core_x0_o, 16'h009B);
      chk("y0", core_y0_o, 0);
    end
    while (!resp_valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (core_start_o) starts++;
    end
    chk("latency", lat, inr ? L + 1 : 0);
    ec = inr ? (z ^ 16'h14F1) : '0;
    es = inr ? (z ^ 16'h1458) : '0;
    chk("resp_id", resp_id_o, g);
    chk("resp_cos", resp_cos_o, ec);
    chk("resp_sin", resp_sin_o, es);
    chk("resp_err", resp_err_o, !inr);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (core_start_o) starts++;
      chk("stall_valid", resp_valid_o, 1);
      chk("stall_fields", {resp_id_o, resp_err_o, resp_cos_o, resp_sin_o}, {2'(g), !inr, ec, es});
      chk("stall_ready", req_ready_o, 0);
    end
    chk("starts", starts, inr ? 1 : 0);
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    chk("resp_drop", resp_valid_o, 0);
  endtask

  initial begin
    int id, cnt;
    logic [W-1:0] rz [6];
    for (int i = 0; i < N; i++) z_arr[i] = '0;

    // Reset and idle
    #2 rst = 1'b1;
    #1 check_reset_outs();
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (core_start_o) cnt++;
    end
    chk("idle_no_start", cnt, 0);

    // Contention: all four at once, then 0 and 2
    for (int i = 0; i < N; i++) begin
      z_arr[i] = rand_z(1'b1);
      req_valid_i[i] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      serve(0, id);
      chk("order_all", id, i);
    end
    z_arr[0] = rand_z(1'b1);
    z_arr[2] = rand_z(1'b1);
    req_valid_i[0] = 1'b1;
    req_valid_i[2] = 1'b1;
    serve(0, id);
    chk("order_pair0", id, 0);
    serve(0, id);
    chk("order_pair1", id, 2);

    // Single directed request
    z_arr[0] = 16'h1400;
    req_valid_i[0] = 1'b1;
    serve(0, id);
    chk("single_id", id, 0);

    // Backpressure with other requests pending
    z_arr[1] = rand_z(1'b1);
    z_arr[3] = rand_z(1'b0);
    req_valid_i[1] = 1'b1;
    req_valid_i[3] = 1'b1;
    serve(10, id);
    serve(0, id);

    // Range boundaries
    rz[0] = 16'h5B00; rz[1] = 16'hA500; rz[2] = 16'h5A00;
    rz[3] = 16'hA600; rz[4] = 16'h8000; rz[5] = 16'h5A01;
    for (int i = 0; i < 6; i++) begin
      id = $urandom_range(0, N - 1);
      z_arr[id] = rz[i];
      req_valid_i[id] = 1'b1;
      serve(1, id);
    end

    // Randomized mixes
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < N; j++) begin
        if (!req_valid_i[j] && $urandom_range(0, 1) == 1) begin
          z_arr[j] = rand_z($urandom_range(0, 3) != 0);
          req_valid_i[j] = 1'b1;
        end
      end
      if (req_valid_i == '0) begin
        z_arr[it % N] = rand_z(1'b1);
        req_valid_i[it % N] = 1'b1;
      end
      serve($urandom_range(0, 3), id);
    end
    while (req_valid_i != '0) serve(0, id);

    // Reset during WAIT; pointer left at 1 by the aborted accept
    z_arr[0] = 16'h1000;
    req_valid_i[0] = 1'b1;
    @(negedge clk);
    chk("abort_grant", req_ready_o, 4'b0001);
    @(posedge clk); #1;
    req_valid_i[0] = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outs();
    @(negedge clk) rst = 1'b0;
    m_ptr = 0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid_o || core_start_o) cnt++;
    end
    chk("abort_quiet", cnt, 0);
    z_arr[0] = rand_z(1'b1);
    z_arr[1] = rand_z(1'b1);
    req_valid_i[0] = 1'b1;
    req_valid_i[1] = 1'b1;
    serve(0, id);
    chk("post_rst_first", id, 0);
    serve(0, id);
    chk("post_rst_second", id, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
